// File: rtl/year_bcd_writer.sv
// Converts the captured 7-bit binary year to packed BCD (double-dabble) and writes it to the RTC year register.
// Latency: busyW rises the cycle after an accepted start; doneW pulses 9+6*T_PHASE cycles after the start edge.
// Backpressure: none; startW is honoured only in IDLE, and is neither queued nor retained otherwise.
module year_bcd_writer #(
    parameter logic [7:0] ADDR_YEAR = 8'h26,
    parameter int         T_PHASE   = 4
) (
    input  logic       clkW,
    input  logic       resetW,
    input  logic       startW,
    input  logic [6:0] yearW,
    output logic       busyW,
    output logic       doneW,
    output logic       errW,
    output logic [7:0] ad_outW,
    output logic       ad_oeW,
    output logic       adW,
    output logic       csW,
    output logic       wrW,
    output logic       rdW
);

    localparam int CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;

    typedef enum logic [3:0] {
        IDLE, CHECK, CONV, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, FIN
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic [CW-1:0]   phaseCnt;
    logic [2:0]      convCnt;
    logic [6:0]      yearReg;
    logic [7:0]      bcdReg;
    logic [7:0]      bcdAdj;
    logic            phaseLast;
    logic            convLast;
    logic            yearBad;
    logic            inAddr;
    logic            inData;

    assign phaseLast = (phaseCnt == CW'(T_PHASE - 1));
    assign convLast  = (convCnt == 3'd6);
    assign yearBad   = (yearReg > 7'd99);
    assign inAddr    = (state == A_SET) || (state == A_STB) || (state == A_HLD);
    assign inData    = (state == D_SET) || (state == D_STB) || (state == D_HLD);

    // Nibble correction applied before each shift of the double-dabble.
    always_comb begin
        bcdAdj = bcdReg;
        if (bcdReg[3:0] >= 4'd5) bcdAdj[3:0] = bcdReg[3:0] + 4'd3;
        if (bcdReg[7:4] >= 4'd5) bcdAdj[7:4] = bcdReg[7:4] + 4'd3;
    end

    always_ff @(posedge clkW) begin
        if (!resetW) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (startW)    stateNext = CHECK;
            CHECK:   stateNext = yearBad ? IDLE : CONV;
            CONV:    if (convLast)  stateNext = A_SET;
            A_SET:   if (phaseLast) stateNext = A_STB;
            A_STB:   if (phaseLast) stateNext = A_HLD;
            A_HLD:   if (phaseLast) stateNext = D_SET;
            D_SET:   if (phaseLast) stateNext = D_STB;
            D_STB:   if (phaseLast) stateNext = D_HLD;
            D_HLD:   if (phaseLast) stateNext = FIN;
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clkW) begin
        if (!resetW) begin
            yearReg  <= 7'd0;
            bcdReg   <= 8'd0;
            convCnt  <= 3'd0;
            phaseCnt <= '0;
        end else begin
            if (state == IDLE && startW) yearReg <= yearW;
            if (state == CHECK) begin
                bcdReg  <= 8'd0;
                convCnt <= 3'd0;
            end
            // Year is consumed MSB first; yearReg is free once converted.
            if (state == CONV) begin
                bcdReg  <= (bcdAdj << 1) | {7'd0, yearReg[6]};
                yearReg <= {yearReg[5:0], 1'b0};
                convCnt <= convCnt + 3'd1;
            end
            if (inAddr || inData) phaseCnt <= phaseLast ? '0 : phaseCnt + 1'b1;
            else                  phaseCnt <= '0;
        end
    end

    // Outputs are decoded from the current state and registered, so they trail the state by one cycle.
    always_ff @(posedge clkW) begin
        if (!resetW) begin
            busyW   <= 1'b0;
            doneW   <= 1'b0;
            errW    <= 1'b0;
            ad_outW <= 8'd0;
            ad_oeW  <= 1'b0;
            adW     <= 1'b0;
            csW     <= 1'b1;
            wrW     <= 1'b1;
            rdW     <= 1'b1;
        end else begin
            busyW   <= (state == CHECK && !yearBad) || (state == CONV) || inAddr || inData;
            doneW   <= (state == FIN);
            errW    <= (state == CHECK) && yearBad;
            ad_outW <= inAddr ? ADDR_YEAR : (inData ? bcdReg : 8'd0);
            ad_oeW  <= inAddr || inData;
            adW     <= inData;
            csW     <= !(inAddr || inData);
            wrW     <= !((state == A_STB) || (state == D_STB));
            rdW     <= 1'b1;
        end
    end

endmodule
